// File: rtl/sa_ctrl_if.sv
// Command and result-stream bundle between the tile controller and sa_ctrl.
// The master side issues start/k_len and consumes result rows; the slave
// side (sa_ctrl) reports busy/done and presents rows with valid/ready.
interface sa_ctrl_if #(
  parameter int N   = 4,
  parameter int ACC = 32,
  parameter int KW  = 8,
  parameter int RW  = 2
);
  logic             start;
  logic [KW-1:0]    k_len;
  logic             busy;
  logic             done;
  logic [N*ACC-1:0] res_row;
  logic             res_valid;
  logic             res_ready;
  logic [RW-1:0]    res_idx;

  modport master (
    output start, k_len, res_ready,
    input  busy, done, res_row, res_valid, res_idx
  );

  modport slave (
    input  start, k_len, res_ready,
    output busy, done, res_row, res_valid, res_idx
  );
endinterface

// File: rtl/sa_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array: clears the
// accumulators, drives skewed operand indices to the edge feeders for the
// exact compute window, then streams the N result rows out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; k_len latched on acceptance
// CLEAR   | one cycle of array accumulator clear (arr_rst_n low)
// FEED    | arr_en high, t counts 0 .. kl+2N-3, operands skewed per lane
// READOUT | row r presented on res_row until handshaken, r = 0 .. N-1
// DONE    | one-cycle done pulse, then back to IDLE
module sa_ctrl #(
  parameter int N    = 4,
  parameter int ACC  = 32,
  parameter int KMAX = 255,
  parameter int KW   = $clog2(KMAX+1),
  parameter int RW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  sa_ctrl_if.slave           cmd,
  output logic               arr_rst_n,
  output logic               arr_en,
  output logic [N-1:0]       a_valid,
  output logic [N*KW-1:0]    a_idx,
  output logic [N-1:0]       b_valid,
  output logic [N*KW-1:0]    b_idx,
  input  logic [N*N*ACC-1:0] acc_flat
);

  // t must reach kl + 2N - 3 without wrapping for any kl <= KMAX
  localparam int TW = KW + RW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_READOUT,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_t, w_t_nxt;
  logic [KW-1:0] r_kl, w_kl_nxt;
  logic [RW-1:0] r_r, w_r_nxt;
  logic [TW-1:0] w_t_last;

  // Last FEED cycle: the final operand reaches PE(N-1,N-1) at kl-1+2(N-1)
  assign w_t_last = TW'(r_kl) + TW'(2*N-3);

  // State and counter registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_kl    <= '0;
      r_r     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_kl    <= w_kl_nxt;
      r_r     <= w_r_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_kl_nxt    = r_kl;
    w_r_nxt     = r_r;
    unique case (r_state)
      S_IDLE: begin
        if (cmd.start) begin
          w_kl_nxt    = cmd.k_len;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_t_nxt = '0;
        w_r_nxt = '0;
        if (r_kl == '0) w_state_nxt = S_READOUT;
        else            w_state_nxt = S_FEED;
      end
      S_FEED: begin
        if (r_t == w_t_last) begin
          w_r_nxt     = '0;
          w_state_nxt = S_READOUT;
        end else begin
          w_t_nxt = r_t + 1'b1;
        end
      end
      S_READOUT: begin
        if (cmd.res_ready) begin
          if (r_r == RW'(N-1)) w_state_nxt = S_DONE;
          else                 w_r_nxt     = r_r + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status, array control and result-stream outputs decoded from state
  always_comb begin
    cmd.busy      = (r_state != S_IDLE);
    cmd.done      = (r_state == S_DONE);
    arr_rst_n     = (r_state != S_CLEAR);
    arr_en        = (r_state == S_FEED);
    cmd.res_valid = (r_state == S_READOUT);
    cmd.res_idx   = '0;
    cmd.res_row   = '0;
    if (r_state == S_READOUT) begin
      cmd.res_idx = r_r;
      cmd.res_row = acc_flat[int'(r_r)*N*ACC +: N*ACC];
    end
  end

  // Operand skew: lane i carries operand index t-i while 0 <= t-i < kl
  always_comb begin
    a_valid = '0;
    a_idx   = '0;
    for (int i = 0; i < N; i++) begin
      logic [TW-1:0] lane_t;
      lane_t = r_t - TW'(i);
      if ((r_state == S_FEED) && (r_t >= TW'(i)) && (lane_t < TW'(r_kl))) begin
        a_valid[i]          = 1'b1;
        a_idx[i*KW +: KW]   = lane_t[KW-1:0];
      end
    end
  end

  // Rows and columns share the same skew schedule
  assign b_valid = a_valid;
  assign b_idx   = a_idx;

endmodule

// File: tb/tb_sa_ctrl.sv
// Bench for sa_ctrl: a behavioural PE array fed from random matrices, with
// readout compared against a plain matrix product and control timing
// compared against the skew/window rules.
module tb_sa_ctrl;
  localparam int N    = 4;
  localparam int ACC  = 32;
  localparam int KMAX = 255;
  localparam int KW   = 8;
  localparam int RW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_ctrl_if #(.N(N), .ACC(ACC), .KW(KW), .RW(RW)) cmd();

  logic               arr_rst_n, arr_en;
  logic [N-1:0]       a_valid, b_valid;
  logic [N*KW-1:0]    a_idx, b_idx;
  logic [N*N*ACC-1:0] acc_flat;

  sa_ctrl #(.N(N), .ACC(ACC), .KMAX(KMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .arr_rst_n(arr_rst_n),
    .arr_en   (arr_en),
    .a_valid  (a_valid),
    .a_idx    (a_idx),
    .b_valid  (b_valid),
    .b_idx    (b_idx),
    .acc_flat (acc_flat)
  );

  int unsigned mat_a [N][KMAX+1];
  int unsigned mat_b [KMAX+1][N];
  logic [ACC-1:0] pe_acc [N][N];
  logic [ACC-1:0] pe_a   [N][N];
  logic [ACC-1:0] pe_b   [N][N];

  int vectors = 0;
  int miscompares = 0;

  // Behavioural PE array with edge feeders
  always @(posedge clk) begin : pe_model
    logic [ACC-1:0] ain, bin;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!rst_n || !arr_rst_n) begin
          pe_acc[r][c] <= '0;
          pe_a[r][c]   <= '0;
          pe_b[r][c]   <= '0;
        end else if (arr_en) begin
          if (c == 0) ain = a_valid[r] ? ACC'(mat_a[r][a_idx[r*KW +: KW]]) : '0;
          else        ain = pe_a[r][c-1];
          if (r == 0) bin = b_valid[c] ? ACC'(mat_b[b_idx[c*KW +: KW]][c]) : '0;
          else        bin = pe_b[r-1][c];
          pe_a[r][c]   <= ain;
          pe_b[r][c]   <= bin;
          pe_acc[r][c] <= pe_acc[r][c] + ain * bin;
        end
      end
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        acc_flat[(r*N+c)*ACC +: ACC] = pe_acc[r][c];
  end

  function automatic logic [ACC-1:0] gold(input int r, input int c, input int kl);
    longint s = 0;
    for (int k = 0; k < kl; k++) s += longint'(mat_a[r][k]) * longint'(mat_b[k][c]);
    return ACC'(s);
  endfunction

  // Runs one full operation and checks window, skew, readout and done timing
  task automatic run_op(input int kl, input int bp_row, input int bp_len,
                        input bit poke, input string tag);
    int  clr_n = 0, en_n = 0, rows = 0, done_n = 0, held = 0, cyc = 0;
    bit  fin = 0, last_hs = 0, hs_now, hold_pending = 0, poked_ro = 0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 16; k++) begin
        mat_a[r][k] = $urandom_range(0, 15);
        mat_b[k][r] = $urandom_range(0, 15);
      end
    cmd.res_ready = 1'b1;
    cmd.start = 1'b1;
    cmd.k_len = KW'(kl);
    @(negedge clk);
    cmd.start = 1'b0;
    cmd.k_len = KW'($urandom);
    while (!fin && cyc < 2000) begin
      cyc++;
      cmd.start = 1'b0;
      hs_now = 1'b0;
      if (done_n > 0) begin
        vectors++;
        if (cmd.busy !== 1'b0 || cmd.done !== 1'b0) begin
          miscompares++;
          $display("FAIL %s post_done busy=%b done=%b expected busy=0 done=0", tag, cmd.busy, cmd.done);
        end
        fin = 1'b1;
      end else begin
        vectors++;
        if (cmd.busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s busy cyc=%0d got=%b expected=1", tag, cyc, cmd.busy);
        end
        if (hold_pending) begin
          vectors++;
          if (cmd.res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s valid_hold got=%b expected=1", tag, cmd.res_valid);
          end
        end
        hold_pending = 1'b0;
        if (arr_rst_n === 1'b0) clr_n++;
        if (arr_en === 1'b1) begin
          for (int i = 0; i < N; i++) begin
            bit ev;
            int ei;
            ev = (en_n >= i) && (en_n - i < kl);
            ei = ev ? en_n - i : 0;
            vectors++;
            if (a_valid[i] !== ev || b_valid[i] !== ev ||
                a_idx[i*KW +: KW] !== KW'(ei) || b_idx[i*KW +: KW] !== KW'(ei)) begin
              miscompares++;
              $display("FAIL %s skew t=%0d lane=%0d got av=%b ai=%0d bv=%b bi=%0d expected v=%b idx=%0d",
                       tag, en_n, i, a_valid[i], a_idx[i*KW +: KW], b_valid[i], b_idx[i*KW +: KW], ev, ei);
            end
          end
          if (poke && en_n == 2) begin
            cmd.start = 1'b1;
            cmd.k_len = KW'(kl + 5);
          end
          en_n++;
        end else begin
          vectors++;
          if (a_valid !== '0 || b_valid !== '0 || a_idx !== '0 || b_idx !== '0) begin
            miscompares++;
            $display("FAIL %s lanes_idle av=%h ai=%h bv=%h bi=%h expected all 0", tag, a_valid, a_idx, b_valid, b_idx);
          end
        end
        if (cmd.res_valid === 1'b1) begin
          vectors++;
          if (cmd.res_idx !== RW'(rows) || arr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL %s res_idx got=%0d en=%b expected=%0d en=0", tag, cmd.res_idx, arr_en, rows);
          end
          for (int c = 0; c < N; c++) begin
            vectors++;
            if (cmd.res_row[c*ACC +: ACC] !== gold(rows, c, kl)) begin
              miscompares++;
              $display("FAIL %s res_row r=%0d c=%0d got=%0d expected=%0d", tag, rows, c,
                       cmd.res_row[c*ACC +: ACC], gold(rows, c, kl));
            end
          end
          if (poke && !poked_ro) begin
            poked_ro = 1'b1;
            cmd.start = 1'b1;
            cmd.k_len = KW'(kl + 7);
          end
          if (rows == bp_row && held < bp_len) begin
            cmd.res_ready = 1'b0;
            held++;
          end else begin
            cmd.res_ready = ($urandom_range(0, 3) != 0);
          end
          if (cmd.res_ready) begin
            rows++;
            hs_now = 1'b1;
          end else begin
            hold_pending = 1'b1;
          end
        end else begin
          cmd.res_ready = $urandom_range(0, 1);
        end
        if (cmd.done === 1'b1) begin
          done_n++;
          vectors++;
          if (rows != N || !last_hs) begin
            miscompares++;
            $display("FAIL %s done_timing rows=%0d prev_handshake=%b expected rows=%0d prev_handshake=1",
                     tag, rows, last_hs, N);
          end
        end
        last_hs = hs_now;
      end
      @(negedge clk);
    end
    cmd.res_ready = 1'b1;
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL %s timeout done_count=%0d expected=1", tag, done_n);
    end
    vectors++;
    if (clr_n != 1) begin
      miscompares++;
      $display("FAIL %s clear_len got=%0d expected=1", tag, clr_n);
    end
    vectors++;
    if (en_n != ((kl == 0) ? 0 : kl + 2*N - 2)) begin
      miscompares++;
      $display("FAIL %s en_len got=%0d expected=%0d", tag, en_n, (kl == 0) ? 0 : kl + 2*N - 2);
    end
    vectors++;
    if (done_n != 1 || rows != N) begin
      miscompares++;
      $display("FAIL %s completion done=%0d rows=%0d expected done=1 rows=%0d", tag, done_n, rows, N);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (cmd.busy !== 1'b0 || cmd.done !== 1'b0 || arr_rst_n !== 1'b1 || arr_en !== 1'b0 ||
        a_valid !== '0 || b_valid !== '0 || a_idx !== '0 || b_idx !== '0 ||
        cmd.res_valid !== 1'b0 || cmd.res_idx !== '0) begin
      miscompares++;
      $display("FAIL %s idle_outputs busy=%b done=%b arst=%b en=%b av=%h bv=%h ai=%h bi=%h rv=%b ri=%0d expected reset values",
               tag, cmd.busy, cmd.done, arr_rst_n, arr_en, a_valid, b_valid, a_idx, b_idx,
               cmd.res_valid, cmd.res_idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd.start = 1'b0;
    cmd.k_len = '0;
    cmd.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_release");
  endtask

  task automatic test_window_k3();
    run_op(3, -1, 0, 1'b0, "window_k3");
  endtask

  task automatic test_matmul();
    run_op(2, -1, 0, 1'b0, "matmul_k2");
    repeat (6) run_op($urandom_range(1, 12), -1, 0, 1'b0, "matmul_rand");
  endtask

  task automatic test_backpressure();
    run_op(4, 1, 5, 1'b0, "backpressure");
  endtask

  task automatic test_k_zero();
    run_op(0, -1, 0, 1'b0, "k_zero");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit saw_done = 0;
    cmd.start = 1'b1;
    cmd.k_len = KW'(5);
    @(negedge clk);
    cmd.start = 1'b0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      if (arr_en === 1'b1) n++;
      if (n < 5) @(negedge clk);
    end
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL reset_mid reach_t4 en_cycles=%0d expected=5", n);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (cmd.done === 1'b1 || cmd.busy !== 1'b0) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL reset_mid no_done got activity=1 expected=0");
    end
    run_op(1, -1, 0, 1'b0, "after_reset_k1");
  endtask

  task automatic test_start_ignored();
    run_op(3, -1, 0, 1'b1, "start_ignored");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_window_k3();
    test_matmul();
    test_backpressure();
    test_k_zero();
    test_reset_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
